// File: rtl/ub_controller_if.sv
// Command, accumulator-handshake and unified-buffer signals of ub_controller.
// master = issue logic / accumulators / buffer side, slave = the controller.
interface ub_controller_if #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_tiles;
  logic              acc1_full;
  logic              acc2_full;
  logic              acc_ack;
  logic              tile_ready;
  logic [ADDR_W-1:0] ub_addr;
  logic              ub_store;
  logic              ub_load_input;
  logic              tile_valid;
  logic              busy;
  logic              done;
  logic              cmd_err;
  logic              timeout;

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_tiles, acc1_full, acc2_full, tile_ready,
    input  cmd_ready, acc_ack, ub_addr, ub_store, ub_load_input, tile_valid,
           busy, done, cmd_err, timeout
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_tiles, acc1_full, acc2_full, tile_ready,
    output cmd_ready, acc_ack, ub_addr, ub_store, ub_load_input, tile_valid,
           busy, done, cmd_err, timeout
  );
endinterface

// File: rtl/ub_controller.sv
// Unified-buffer sequencer for multi-tile STORE/LOAD commands; all outputs registered.
// Optional store-wait timeout: define UBC_TIMEOUT_EN.
module ub_controller #(
  parameter int ADDR_W      = 13,
  parameter int MEM_DEPTH   = 64,
  parameter int TILE_WORDS  = 4,
  parameter int CNT_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           reset,
  ub_controller_if.slave bus,
  output logic [2:0]     o_dbg_state
);
  // Command handshake: a command transfers in a cycle where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE, so commands offered while busy are ignored.
  typedef enum logic [2:0] {
    S_IDLE, S_ST_WAIT, S_ST_ISSUE, S_LD_WAIT, S_LD_ISSUE, S_DONE
  } state_t;

  localparam int SUM_W = ADDR_W + CNT_W + 2;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_remain;
  logic              r_ign;
  logic              w_accept, w_reject, w_abort, w_last, w_oob, w_to_hit;
  logic [SUM_W-1:0]  w_end;

  logic r_cmd_ready, r_acc_ack, r_store, r_load, r_tile_valid, r_busy, r_done, r_err, r_timeout;
  logic w_cmd_ready_d, w_acc_ack_d, w_store_d, w_load_d, w_tile_valid_d, w_busy_d, w_done_d,
        w_err_d, w_timeout_d;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 8-bit wait counter");
  end

  // Wide sum so a large base plus many tiles can never wrap past the bound.
  assign w_end  = SUM_W'(bus.cmd_base) + SUM_W'(bus.cmd_tiles) * SUM_W'(TILE_WORDS);
  assign w_oob  = w_end > SUM_W'(MEM_DEPTH);
  assign w_last = (r_remain == CNT_W'(1));

`ifdef UBC_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  assign w_to_hit = (r_wait_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (reset) r_wait_cnt <= 8'd0;
    else       r_wait_cnt <= (r_state == S_ST_WAIT && w_next == S_ST_WAIT) ? r_wait_cnt + 8'd1 : 8'd0;
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (w_oob) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            if (bus.cmd_tiles == '0) w_next = S_DONE;
            else if (bus.cmd_op)     w_next = S_LD_WAIT;
            else                     w_next = S_ST_WAIT;
          end
        end
      end
      // First wait cycle after a store ignores the full flags while they drop.
      S_ST_WAIT: begin
        if (!r_ign && bus.acc1_full && bus.acc2_full) begin
          w_next = S_ST_ISSUE;
        end else if (w_to_hit) begin
          w_abort = 1'b1;
          w_next  = S_DONE;
        end
      end
      S_ST_ISSUE: w_next = w_last ? S_DONE : S_ST_WAIT;
      S_LD_WAIT:  if (bus.tile_ready) w_next = S_LD_ISSUE;
      S_LD_ISSUE: w_next = w_last ? S_DONE : S_LD_WAIT;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Output values are decoded from the next state so the registered outputs line up with it.
  always_comb begin
    w_cmd_ready_d  = (w_next == S_IDLE);
    w_busy_d       = (w_next != S_IDLE);
    w_store_d      = (w_next == S_ST_ISSUE);
    w_acc_ack_d    = (w_next == S_ST_ISSUE);
    w_load_d       = (w_next == S_LD_ISSUE);
    w_tile_valid_d = (r_state == S_LD_ISSUE);
    w_done_d       = (w_next == S_DONE);
    w_err_d        = w_reject;
    w_timeout_d    = w_abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd_ready  <= 1'b1;
      r_acc_ack    <= 1'b0;
      r_store      <= 1'b0;
      r_load       <= 1'b0;
      r_tile_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_cmd_ready  <= w_cmd_ready_d;
      r_acc_ack    <= w_acc_ack_d;
      r_store      <= w_store_d;
      r_load       <= w_load_d;
      r_tile_valid <= w_tile_valid_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
      r_err        <= w_err_d;
      r_timeout    <= w_timeout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_ign    <= 1'b0;
    end else begin
      r_ign <= (r_state == S_ST_ISSUE);
      if (w_accept) begin
        r_addr   <= bus.cmd_base;
        r_remain <= bus.cmd_tiles;
      end else if (r_state == S_ST_ISSUE || r_state == S_LD_ISSUE) begin
        r_addr   <= r_addr + ADDR_W'(TILE_WORDS);
        r_remain <= r_remain - CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready     = r_cmd_ready;
  assign bus.acc_ack       = r_acc_ack;
  assign bus.ub_addr       = r_addr;
  assign bus.ub_store      = r_store;
  assign bus.ub_load_input = r_load;
  assign bus.tile_valid    = r_tile_valid;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.cmd_err       = r_err;
  assign bus.timeout       = r_timeout;
  assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_ub_controller.sv
// Self-checking bench for ub_controller: reset values, table of commands, directed
// corner sequences and random commands scored against a transaction-level model.
module tb_ub_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;
  int         cyc = 0;

  ub_controller_if #(.ADDR_W(13), .CNT_W(5)) bus();

  ub_controller #(.ADDR_W(13), .MEM_DEPTH(64), .TILE_WORDS(4), .CNT_W(5), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_dbg_state(dbg_state)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  // Model state: expected strobes as {op, addr}, and the cycles where done/cmd_err must pulse.
  logic [13:0] exp_q[$];
  int          log_q[$];
  int          exp_done_cyc = -1;
  int          exp_err_cyc  = -1;
  int          acc_cyc = -100;
  int          mdl_left = 0;
  bit          cmd_open = 0;
  bit          open_err = 0;
  bit          mon_en = 0;
  int          n_store = 0, n_load = 0, n_ack = 0, n_err_seen = 0;
  int          last_store_cyc = -100;
  int          done_seen_cyc = -1;
  logic        prev_load = 0, prev_both = 0, prev_tr = 0;
  logic [13:0] mon_e;
  logic        mon_busy;

  bit   acc_auto = 0;
  logic man1 = 0, man2 = 0;
  int   drop_cnt = 0, raise_wait = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Accumulator model: full flags rise after a short random delay and fall two cycles after acc_ack.
  initial begin
    bus.acc1_full = 1'b0;
    bus.acc2_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!acc_auto) begin
        bus.acc1_full = man1;
        bus.acc2_full = man2;
        drop_cnt = 0;
      end else if (bus.acc_ack) begin
        drop_cnt = 2;
      end else if (drop_cnt > 0) begin
        drop_cnt--;
        if (drop_cnt == 0) begin
          bus.acc1_full = 1'b0;
          bus.acc2_full = 1'b0;
          raise_wait = $urandom_range(0, 3);
        end
      end else if (!(bus.acc1_full && bus.acc2_full)) begin
        if (raise_wait == 0) begin
          bus.acc1_full = 1'b1;
          bus.acc2_full = 1'b1;
        end else raise_wait--;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk1("one_strobe", bus.ub_store && bus.ub_load_input, 1'b0);
      chk1("ack_with_store", bus.acc_ack, bus.ub_store);
      chk1("tile_valid", bus.tile_valid, prev_load);
      chk1("done", bus.done, cyc == exp_done_cyc);
      chk1("cmd_err", bus.cmd_err, cyc == exp_err_cyc);
      mon_busy = cmd_open && !open_err && (cyc > acc_cyc);
      chk1("busy", bus.busy, mon_busy);
      chk1("cmd_ready", bus.cmd_ready, !mon_busy);
`ifndef UBC_TIMEOUT_EN
      chk1("timeout_low", bus.timeout, 1'b0);
`endif
      if (bus.ub_store || bus.ub_load_input) begin
        log_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk1("unexpected_strobe", 1'b1, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk1("strobe_op", bus.ub_load_input, mon_e[13]);
          chk("strobe_addr", int'(bus.ub_addr), int'(mon_e[12:0]));
          mdl_left--;
          if (mdl_left == 0) exp_done_cyc = cyc + 1;
        end
        if (bus.ub_store) begin
          chk1("store_needs_full", prev_both, 1'b1);
          chk1("store_gap", (cyc - last_store_cyc) >= 3, 1'b1);
          last_store_cyc = cyc;
          n_store++;
        end else begin
          chk1("load_needs_ready", prev_tr, 1'b1);
          n_load++;
        end
      end
      if (bus.acc_ack) n_ack++;
      if (bus.cmd_err) n_err_seen++;
      if (bus.done) done_seen_cyc = cyc;
      if (cmd_open && (cyc == exp_done_cyc || cyc == exp_err_cyc)) cmd_open = 0;
    end
    prev_load = bus.ub_load_input;
    prev_both = bus.acc1_full && bus.acc2_full;
    prev_tr   = bus.tile_ready;
  end

  // Offers one command for one cycle while the controller is idle and records what it must do.
  task automatic issue_cmd(input logic op, input int base, input int tiles);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_base  = 13'(base);
    bus.cmd_tiles = 5'(tiles);
    acc_cyc  = cyc;
    cmd_open = 1;
    open_err = (base + tiles * 4) > 64;
    if (open_err) exp_err_cyc = cyc + 1;
    else if (tiles == 0) exp_done_cyc = cyc + 1;
    else begin
      mdl_left = tiles;
      for (int k = 0; k < tiles; k++) exp_q.push_back({op, 13'(base + 4 * k)});
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_cmd(input bit junk, input bit rand_tr);
    for (int k = 0; k < 2000; k++) begin
      if (!cmd_open) break;
      @(posedge clk); #1;
      bus.cmd_valid = cmd_open && junk && ($urandom_range(0, 3) == 0);
      bus.cmd_op    = 1'($urandom_range(0, 1));
      bus.cmd_base  = 13'($urandom_range(0, 40));
      bus.cmd_tiles = 5'($urandom_range(0, 4));
      if (rand_tr) bus.tile_ready = ($urandom_range(0, 2) != 0);
    end
    bus.cmd_valid = 1'b0;
    if (cmd_open) begin
      chk1("cmd_completes", 1'b0, 1'b1);
      cmd_open = 0;
      exp_q.delete();
    end
  endtask

  typedef struct {
    logic op;
    int   base;
    int   tiles;
    logic exp_err;
    int   exp_strobes;
  } vec_t;

  vec_t vecs[12];
  int   s0, e0, a0, base_r;

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = '0; bus.cmd_tiles = '0;
    bus.tile_ready = 1'b0;

    vecs[0]  = '{1'b1, 0,    3,  1'b0, 3};
    vecs[1]  = '{1'b1, 60,   2,  1'b1, 0};
    vecs[2]  = '{1'b0, 60,   1,  1'b0, 1};
    vecs[3]  = '{1'b0, 56,   2,  1'b0, 2};
    vecs[4]  = '{1'b1, 64,   0,  1'b0, 0};
    vecs[5]  = '{1'b0, 61,   1,  1'b1, 0};
    vecs[6]  = '{1'b1, 0,    16, 1'b0, 16};
    vecs[7]  = '{1'b1, 0,    17, 1'b1, 0};
    vecs[8]  = '{1'b0, 8191, 31, 1'b1, 0};
    vecs[9]  = '{1'b0, 8,    0,  1'b0, 0};
    vecs[10] = '{1'b1, 4,    15, 1'b0, 15};
    vecs[11] = '{1'b0, 65,   0,  1'b1, 0};

    repeat (3) @(negedge clk);
    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_store", bus.ub_store, 1'b0);
    chk1("rst_load", bus.ub_load_input, 1'b0);
    chk1("rst_ack", bus.acc_ack, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk("rst_addr", int'(bus.ub_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1;

    // STORE base 8, two tiles, accumulators filling and draining on their own.
    acc_auto = 1;
    s0 = n_store; a0 = n_ack;
    log_q.delete();
    issue_cmd(1'b0, 8, 2);
    wait_cmd(0, 0);
    chk("st2_stores", n_store - s0, 2);
    chk("st2_acks", n_ack - a0, 2);
    if (log_q.size() == 2) chk("st2_done_after_store", done_seen_cyc, log_q[1] + 1);
    else chk("st2_strobe_count", log_q.size(), 2);

    // LOAD base 0, three tiles, tile_ready held high: strobes every other cycle.
    bus.tile_ready = 1'b1;
    log_q.delete();
    issue_cmd(1'b1, 0, 3);
    wait_cmd(0, 0);
    if (log_q.size() == 3) begin
      chk("ld3_first", log_q[0] - acc_cyc, 2);
      chk("ld3_second", log_q[1] - acc_cyc, 4);
      chk("ld3_third", log_q[2] - acc_cyc, 6);
    end else chk("ld3_strobe_count", log_q.size(), 3);
    chk("ld3_done", done_seen_cyc - acc_cyc, 7);

    // STORE one tile while only acc1 is full for 10 cycles.
    @(negedge clk);
    acc_auto = 0; man1 = 1'b1; man2 = 1'b0;
    s0 = n_store;
    issue_cmd(1'b0, 20, 1);
    repeat (10) @(posedge clk);
    chk("one_flag_no_store", n_store - s0, 0);
    @(negedge clk);
    man2 = 1'b1;
    wait_cmd(0, 0);
    chk("both_flags_store", n_store - s0, 1);
    @(negedge clk);
    man1 = 1'b0; man2 = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while a three-tile STORE waits for the accumulators.
    mon_en = 0;
    issue_cmd(1'b0, 0, 3);
    @(negedge clk);
    chk1("pre_rst_busy", bus.busy, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("mid_rst_busy", bus.busy, 1'b0);
    chk1("mid_rst_ready", bus.cmd_ready, 1'b1);
    man1 = 1'b1; man2 = 1'b1;
    s0 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.ub_store || bus.acc_ack) s0++;
    end
    chk("mid_rst_no_store", s0, 0);
    man1 = 1'b0; man2 = 1'b0;
    cmd_open = 0; open_err = 0; mdl_left = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    mon_en = 1;
    acc_auto = 1;

    // Table of commands: rejection and strobe counts at the bounds.
    bus.tile_ready = 1'b1;
    foreach (vecs[i]) begin
      e0 = n_err_seen;
      s0 = n_store + n_load;
      issue_cmd(vecs[i].op, vecs[i].base, vecs[i].tiles);
      wait_cmd(!open_err, 0);
      chk($sformatf("vec%0d_err", i), n_err_seen - e0, int'(vecs[i].exp_err));
      chk($sformatf("vec%0d_strobes", i), n_store + n_load - s0, vecs[i].exp_strobes);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Random commands with random tile_ready and ignored commands offered while busy.
    for (int i = 0; i < 40; i++) begin
      base_r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8191)) : int'($urandom_range(0, 68));
      issue_cmd(1'($urandom_range(0, 1)), base_r, int'($urandom_range(0, 18)));
      wait_cmd(!open_err, 1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ub_controller.md
Name: ub_controller

Overview:
- Sequences the unified buffer (64 x 32-bit words, accessed as 4-word tiles) for multi-tile STORE and LOAD commands.
- STORE: waits until both accumulators report full, then pulses the buffer store strobe once per tile.
- LOAD: pulses load_input once per tile and flags when the buffer's registered tile outputs are valid for the input setup buffer.
- Sits between the top-level instruction issue logic and the unified buffer/accumulator pair.

Parameters:
- ADDR_W, 13, width of buffer address and command base address.
- MEM_DEPTH, 64, buffer depth in words; used for bounds check.
- TILE_WORDS, 4, words per tile; address step per tile.
- CNT_W, 5, width of tile count field.
- TIMEOUT_CYC, 255, store-wait cycle limit (only with UBC_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller accepts command (high only in IDLE)
- cmd_op  in  1  0 = STORE, 1 = LOAD
- cmd_base  in  ADDR_W  first word address
- cmd_tiles  in  CNT_W  number of tiles; 0 is legal, no-op
- acc1_full  in  1  accumulator 1 full flag
- acc2_full  in  1  accumulator 2 full flag
- acc_ack  out  1  one-cycle pulse: accumulators drained, clear full
- tile_ready  in  1  input setup buffer can take a tile
- ub_addr  out  ADDR_W  buffer address
- ub_store  out  1  buffer store strobe
- ub_load_input  out  1  buffer load strobe
- tile_valid  out  1  buffer tile outputs valid this cycle
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse at command completion
- cmd_err  out  1  one-cycle pulse: command rejected
- timeout  out  1  one-cycle pulse (UBC_TIMEOUT_EN only, else tied 0)

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0 except cmd_ready = 1. State = IDLE. Reset mid-command aborts it at the next edge with no further strobes; buffer contents are not touched.
- FSM states: IDLE, ST_WAIT, ST_ISSUE, LD_WAIT, LD_ISSUE, DONE.
- IDLE accept: cmd_valid && cmd_ready latches op, base, tiles; the address counter is set to base and the remaining-tile counter to tiles.
- Bounds check at accept: if base + tiles*TILE_WORDS > MEM_DEPTH (computed at ADDR_W+CNT_W+2 bits, no wrap), pulse cmd_err next cycle and stay IDLE.
- tiles == 0 goes directly to DONE.
- Otherwise the next state is ST_WAIT for STORE or LD_WAIT for LOAD.
- ST_WAIT: when acc1_full && acc2_full are both sampled high, go to ST_ISSUE. While waiting, ub_addr holds the current address.
- ST_ISSUE (one cycle): ub_store = 1, ub_addr = current address, acc_ack = 1 in the same cycle. Then address += TILE_WORDS and remaining -= 1. Next state is DONE if remaining was 1, else ST_WAIT.
- Accumulators must drop their full flags by the cycle after acc_ack. The controller ignores the full flags during that cycle: it stays in ST_WAIT for at least one cycle between consecutive stores.
- LD_WAIT: when tile_ready is high, go to LD_ISSUE.
- LD_ISSUE (one cycle): ub_load_input = 1 with the current address. tile_valid pulses in the following cycle, matching the buffer's one-cycle registered read latency. Address and remaining counters update as in ST_ISSUE. Next state is DONE or LD_WAIT.
- tile_valid for the last tile coincides with the DONE cycle.
- DONE (one cycle): done = 1, then IDLE. cmd_ready rises again in IDLE.
- ub_store and ub_load_input are never high in the same cycle.
- Neither strobe is asserted outside ST_ISSUE / LD_ISSUE.
- busy = 1 in every state except IDLE.
- cmd_valid while busy is ignored; the command is not latched.

Optional Feature:
- UBC_TIMEOUT_EN defined:
  - An 8-bit counter increments each cycle in ST_WAIT and clears on leaving it.
  - If it reaches TIMEOUT_CYC, timeout pulses, the command aborts without further strobes, and the FSM goes to DONE.
  - Remaining tiles are discarded.
- Undefined: no counter; timeout is constant 0; ST_WAIT waits indefinitely.

Test Plan:
- Reset, then STORE base = 8, tiles = 2. Raise both full flags at cycle 3 and clear them after each acc_ack → ub_store pulses at addr 8 and addr 12; 2 acc_ack pulses; done one cycle after the second store.
- LOAD base = 0, tiles = 3, tile_ready constantly 1 → ub_load_input at addr 0, 4, 8 on alternating cycles; tile_valid one cycle after each; done coincides with the third tile_valid.
- LOAD base = 60, tiles = 2 (needs 68 > 64) → cmd_err pulse, no strobes, cmd_ready stays 1.
- STORE tiles = 1 with only acc1_full high for 10 cycles, then acc2_full high → no store until both are high; exactly one store at base.
- Assert reset during ST_WAIT of a 3-tile STORE → next cycle: busy = 0, cmd_ready = 1; no further ub_store.
- With UBC_TIMEOUT_EN and TIMEOUT_CYC = 20: STORE with full flags held low → timeout pulse after 20 wait cycles, then done, then IDLE.
